// File: rtl/maze_pkg.sv
// Shared types and direction helpers for the depth-first maze controller.
package maze_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    RIGHT = 2'b01,
    LEFT  = 2'b10,
    DOWN  = 2'b11
  } dir_t;

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_ARM         = 4'd1,
    S_INIT        = 4'd2,
    S_TRY         = 4'd3,
    S_RD          = 4'd4,
    S_WAIT        = 4'd5,
    S_MOVE        = 4'd6,
    S_NEXT        = 4'd7,
    S_BACK        = 4'd8,
    S_POP         = 4'd9,
    S_WIN         = 4'd10,
    S_REPLAY_INIT = 4'd11,
    S_REPLAY      = 4'd12,
    S_HOLD        = 4'd13,
    S_FAIL        = 4'd14
  } state_t;

  // The encoding pairs each direction with its bitwise complement.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(~d);
  endfunction

  // Each priority mode is a fixed XOR permutation of the attempt index k.
  function automatic dir_t order(input logic [1:0] mode, input logic [1:0] k);
    case (mode)
      2'b00:   return dir_t'(k);
      2'b01:   return dir_t'(k ^ 2'b01);
      2'b10:   return dir_t'(k ^ 2'b11);
      default: return dir_t'(k ^ 2'b10);
    endcase
  endfunction

endpackage

// File: rtl/maze_step_unit.sv
// Combinational one-cell step with wrap detection at the maze border.
module maze_step_unit
  import maze_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic [CW-1:0] i_cur_x,
  input  logic [CW-1:0] i_cur_y,
  input  dir_t          i_dir,
  output logic [CW-1:0] o_next_x,
  output logic [CW-1:0] o_next_y,
  output logic          o_out_of_bounds
);

  localparam logic [CW-1:0] ONE = CW'(1);

  always_comb begin
    o_next_x        = i_cur_x;
    o_next_y        = i_cur_y;
    o_out_of_bounds = 1'b0;
    case (i_dir)
      UP: begin
        o_next_y        = i_cur_y + ONE;
        o_out_of_bounds = &i_cur_y;
      end
      RIGHT: begin
        o_next_x        = i_cur_x + ONE;
        o_out_of_bounds = &i_cur_x;
      end
      LEFT: begin
        o_next_x        = i_cur_x - ONE;
        o_out_of_bounds = ~|i_cur_x;
      end
      default: begin
        o_next_y        = i_cur_y - ONE;
        o_out_of_bounds = ~|i_cur_y;
      end
    endcase
  end

endmodule

// File: rtl/maze_dfs_ctrl.sv
// Depth-first maze solver: searches with an external stack/deque and
// replays the found path front-to-back from the same deque.
module maze_dfs_ctrl
  import maze_pkg::*;
#(
  parameter int CW        = 4,
  parameter int MAX_STEPS = 1024,
  parameter int SCW       = 11
) (
  input  logic           Clk,
  input  logic           Rst_n,
  input  logic           Start,
  input  logic           Run,
  input  logic [1:0]     prio_mode,
  input  logic [CW-1:0]  start_x,
  input  logic [CW-1:0]  start_y,
  input  logic [CW-1:0]  goal_x,
  input  logic [CW-1:0]  goal_y,
  output logic [CW-1:0]  mem_x,
  output logic [CW-1:0]  mem_y,
  output logic           mem_rd,
  input  logic           mem_valid,
  input  logic           mem_dout,
  output logic           mem_wr,
  output logic           dq_clr,
  output logic           dq_push,
  output logic [1:0]     dq_din,
  output logic           dq_pop_back,
  output logic           dq_pop_front,
  input  logic [1:0]     dq_back,
  input  logic [1:0]     dq_front,
  input  logic           dq_empty,
  input  logic           dq_full,
  output logic [CW-1:0]  cur_x,
  output logic [CW-1:0]  cur_y,
  output logic [SCW-1:0] step_count,
  output logic           busy,
  output logic           Done,
  output logic           Fail,
  output logic           path_valid,
  output logic [1:0]     path_dir
);

  localparam logic [SCW-1:0] MAX_CNT = SCW'(MAX_STEPS);

  state_t         r_state;
  dir_t           r_dir;
  logic [1:0]     r_k;
  logic [1:0]     r_mode;
  logic [CW-1:0]  r_cur_x, r_cur_y;
  logic [CW-1:0]  r_cand_x, r_cand_y;
  logic [CW-1:0]  r_start_x, r_start_y;
  logic [CW-1:0]  r_goal_x, r_goal_y;
  logic [SCW-1:0] r_step;

  dir_t           w_dir;
  logic [CW-1:0]  w_next_x, w_next_y;
  logic           w_oob;
  logic [SCW-1:0] w_step_inc;
  logic           w_cand_is_goal;

  // One step unit serves search, backtrack (reversed) and replay.
  always_comb begin
    w_dir = order(r_mode, r_k);
    case (r_state)
      S_POP:    w_dir = opposite(dir_t'(dq_back));
      S_REPLAY: w_dir = dir_t'(dq_front);
      default:  ;
    endcase
  end

  maze_step_unit #(.CW(CW)) u_step (
    .i_cur_x         (r_cur_x),
    .i_cur_y         (r_cur_y),
    .i_dir           (w_dir),
    .o_next_x        (w_next_x),
    .o_next_y        (w_next_y),
    .o_out_of_bounds (w_oob)
  );

  assign w_step_inc     = r_step + SCW'(1);
  assign w_cand_is_goal = (r_cand_x == r_goal_x) && (r_cand_y == r_goal_y);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state   <= S_IDLE;
      r_dir     <= UP;
      r_k       <= 2'd0;
      r_mode    <= 2'd0;
      r_cur_x   <= '0;
      r_cur_y   <= '0;
      r_cand_x  <= '0;
      r_cand_y  <= '0;
      r_start_x <= '0;
      r_start_y <= '0;
      r_goal_x  <= '0;
      r_goal_y  <= '0;
      r_step    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (Start) r_state <= S_ARM;
        S_ARM:  if (!Start) r_state <= S_INIT;
        S_INIT: begin
          r_mode    <= prio_mode;
          r_start_x <= start_x;
          r_start_y <= start_y;
          r_goal_x  <= goal_x;
          r_goal_y  <= goal_y;
          r_cur_x   <= start_x;
          r_cur_y   <= start_y;
          r_step    <= '0;
          r_k       <= 2'd0;
          r_state   <= (start_x == goal_x && start_y == goal_y) ? S_WIN : S_TRY;
        end
        S_TRY: begin
          r_dir <= w_dir;
          if (w_oob) begin
            r_state <= S_NEXT;
          end else begin
            r_cand_x <= w_next_x;
            r_cand_y <= w_next_y;
            r_state  <= S_RD;
          end
        end
        S_RD:   r_state <= S_WAIT;
        S_WAIT: if (mem_valid) r_state <= mem_dout ? S_NEXT : S_MOVE;
        S_MOVE: begin
          if (dq_full) begin
            r_state <= S_FAIL;
          end else begin
            r_cur_x <= r_cand_x;
            r_cur_y <= r_cand_y;
            r_step  <= w_step_inc;
            r_k     <= 2'd0;
            if (w_cand_is_goal)             r_state <= S_WIN;
            else if (w_step_inc == MAX_CNT) r_state <= S_FAIL;
            else                            r_state <= S_TRY;
          end
        end
        S_NEXT: begin
          if (r_k == 2'd3) begin
            r_state <= S_BACK;
          end else begin
            r_k     <= r_k + 2'd1;
            r_state <= S_TRY;
          end
        end
        S_BACK: r_state <= dq_empty ? S_FAIL : S_POP;
        S_POP: begin
          r_cur_x <= w_next_x;
          r_cur_y <= w_next_y;
          r_k     <= 2'd0;
          r_state <= S_TRY;
        end
        S_WIN: begin
          if (Start)    r_state <= S_ARM;
          else if (Run) r_state <= S_REPLAY_INIT;
        end
        S_REPLAY_INIT: begin
          r_cur_x <= r_start_x;
          r_cur_y <= r_start_y;
          r_state <= S_REPLAY;
        end
        S_REPLAY: begin
          if (dq_empty) begin
            r_state <= S_HOLD;
          end else begin
            r_cur_x <= w_next_x;
            r_cur_y <= w_next_y;
          end
        end
        S_HOLD, S_FAIL: if (Start) r_state <= S_ARM;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The visited mark for the start cell is written while start is still on the inputs.
  assign mem_x        = (r_state == S_INIT) ? start_x : r_cand_x;
  assign mem_y        = (r_state == S_INIT) ? start_y : r_cand_y;
  assign mem_rd       = (r_state == S_RD);
  assign dq_push      = (r_state == S_MOVE) && !dq_full;
  assign mem_wr       = (r_state == S_INIT) || dq_push;
  assign dq_clr       = (r_state == S_INIT);
  assign dq_din       = dq_push ? r_dir : 2'b00;
  assign dq_pop_back  = (r_state == S_POP);
  assign dq_pop_front = (r_state == S_REPLAY) && !dq_empty;
  assign path_valid   = dq_pop_front;
  assign path_dir     = dq_pop_front ? dq_front : 2'b00;
  assign cur_x        = r_cur_x;
  assign cur_y        = r_cur_y;
  assign step_count   = r_step;
  assign busy         = !(r_state inside {S_IDLE, S_WIN, S_FAIL, S_HOLD});
  assign Done         = (r_state == S_WIN);
  assign Fail         = (r_state == S_FAIL);

endmodule

// File: tb/tb_maze_dfs_ctrl.sv
// Directed and randomized searches against a plain array-based DFS model,
// with bench-side maze memory (variable latency) and deque models.
module tb_maze_dfs_ctrl;

  localparam int CW   = 4;
  localparam int MAXS = 24;
  localparam int SCW  = 11;

  logic          Clk = 1'b0, Rst_n = 1'b0, Start = 1'b0, Run = 1'b0;
  logic [1:0]    prio_mode = 2'd0;
  logic [CW-1:0] start_x = '0, start_y = '0, goal_x = '0, goal_y = '0;
  logic [CW-1:0] mem_x, mem_y, cur_x, cur_y;
  logic          mem_rd, mem_valid, mem_dout, mem_wr;
  logic          dq_clr, dq_push, dq_pop_back, dq_pop_front, dq_empty, dq_full;
  logic [1:0]    dq_din, dq_back, dq_front, path_dir;
  logic [SCW-1:0] step_count;
  logic          busy, Done, Fail, path_valid;

  maze_dfs_ctrl #(.CW(CW), .MAX_STEPS(MAXS), .SCW(SCW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Run(Run), .prio_mode(prio_mode),
    .start_x(start_x), .start_y(start_y), .goal_x(goal_x), .goal_y(goal_y),
    .mem_x(mem_x), .mem_y(mem_y), .mem_rd(mem_rd), .mem_valid(mem_valid),
    .mem_dout(mem_dout), .mem_wr(mem_wr), .dq_clr(dq_clr), .dq_push(dq_push),
    .dq_din(dq_din), .dq_pop_back(dq_pop_back), .dq_pop_front(dq_pop_front),
    .dq_back(dq_back), .dq_front(dq_front), .dq_empty(dq_empty), .dq_full(dq_full),
    .cur_x(cur_x), .cur_y(cur_y), .step_count(step_count), .busy(busy),
    .Done(Done), .Fail(Fail), .path_valid(path_valid), .path_dir(path_dir)
  );

  always #5 Clk = ~Clk;

  wire [40:0] outs = {mem_x, mem_y, mem_rd, mem_wr, dq_clr, dq_push, dq_din, dq_pop_back,
                      dq_pop_front, cur_x, cur_y, step_count, busy, Done, Fail,
                      path_valid, path_dir};

  // Maze memory: walls set by the bench, visited bits written by the DUT.
  bit         wall[256];
  bit         visited[256];
  logic       mem_clear = 1'b0;
  int         lat_fixed = 0;
  int         lat_cnt = 0;
  logic [7:0] rd_addr = '0;

  always @(posedge Clk) begin
    if (mem_clear) foreach (visited[i]) visited[i] <= 1'b0;
    else if (mem_wr) visited[{mem_y, mem_x}] <= 1'b1;
  end

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      lat_cnt <= 0;
    end else if (mem_rd) begin
      rd_addr <= {mem_y, mem_x};
      lat_cnt <= (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
    end else if (lat_cnt > 0) begin
      lat_cnt <= lat_cnt - 1;
    end
  end

  assign mem_valid = (lat_cnt == 1);
  assign mem_dout  = wall[rd_addr] | visited[rd_addr];

  // Deque as a ring buffer: back = newest, front = oldest.
  logic [1:0] dq_mem[256];
  logic [7:0] dq_head = '0;
  int         dq_cnt = 0;
  int         dq_depth = 64;

  always @(posedge Clk) begin
    if (dq_clr) begin
      dq_cnt <= 0;
    end else if (dq_push) begin
      dq_mem[8'(dq_head + dq_cnt)] <= dq_din;
      dq_cnt <= dq_cnt + 1;
    end else if (dq_pop_back) begin
      dq_cnt <= dq_cnt - 1;
    end else if (dq_pop_front) begin
      dq_head <= dq_head + 8'd1;
      dq_cnt  <= dq_cnt - 1;
    end
  end

  assign dq_empty = (dq_cnt == 0);
  assign dq_full  = (dq_cnt >= dq_depth);
  assign dq_back  = dq_mem[8'(dq_head + dq_cnt - 1)];
  assign dq_front = dq_mem[dq_head];

  int total = 0, bad = 0;
  int n_push, n_pop, both;
  int m_win, m_steps, m_pops, m_curx, m_cury;
  int m_path[$];
  int got[$];

  int ORD[4][4] = '{'{0, 1, 2, 3}, '{1, 0, 3, 2}, '{3, 2, 1, 0}, '{2, 3, 0, 1}};
  int DX[4] = '{0, 1, -1, 0};
  int DY[4] = '{1, 0, 0, -1};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Plain DFS: always take the first open, unvisited neighbour in priority order.
  task automatic model(input int sx, input int sy, input int gx, input int gy, input int mode);
    bit v[256];
    int cx, cy, nx, ny, d, f;
    foreach (v[i]) v[i] = 1'b0;
    m_path.delete();
    m_steps = 0; m_pops = 0; m_win = 0;
    cx = sx; cy = sy;
    v[cy*16 + cx] = 1'b1;
    if (sx == gx && sy == gy) m_win = 1;
    else forever begin
      f = -1;
      for (int k = 0; k < 4; k++) begin
        d = ORD[mode][k];
        nx = cx + DX[d]; ny = cy + DY[d];
        if (f < 0 && nx >= 0 && nx < 16 && ny >= 0 && ny < 16)
          if (!wall[ny*16 + nx] && !v[ny*16 + nx]) f = d;
      end
      if (f >= 0) begin
        if (m_path.size() >= dq_depth) break;
        cx += DX[f]; cy += DY[f];
        v[cy*16 + cx] = 1'b1;
        m_path.push_back(f);
        m_steps++;
        if (cx == gx && cy == gy) begin m_win = 1; break; end
        if (m_steps == MAXS) break;
      end else begin
        if (m_path.size() == 0) break;
        d = m_path.pop_back();
        cx -= DX[d]; cy -= DY[d];
        m_pops++;
      end
    end
    m_curx = cx; m_cury = cy;
  endtask

  task automatic clear_visited();
    @(negedge Clk) mem_clear = 1'b1;
    @(negedge Clk) mem_clear = 1'b0;
  endtask

  task automatic replay(input int gx, input int gy);
    int hold_ok = 0;
    got.delete();
    @(negedge Clk) Run = 1'b1;
    @(negedge Clk) Run = 1'b0;
    repeat (600) begin
      if (path_valid) got.push_back(int'(path_dir));
      if (!busy && !Done && !Fail) begin hold_ok = 1; break; end
      @(negedge Clk);
    end
    chk("replay_hold", hold_ok, 1);
    chk("path_len", got.size(), m_path.size());
    for (int i = 0; i < got.size() && i < m_path.size(); i++) chk("path_dir", got[i], m_path[i]);
    chk("replay_end_x", cur_x, gx);
    chk("replay_end_y", cur_y, gy);
  endtask

  task automatic search(input int sx, input int sy, input int gx, input int gy,
                        input int mode, output int cyc);
    int timed_out = 1;
    clear_visited();
    start_x = CW'(sx); start_y = CW'(sy); goal_x = CW'(gx); goal_y = CW'(gy);
    prio_mode = 2'(mode);
    Start = 1'b1;
    @(negedge Clk) Start = 1'b0;
    n_push = 0; n_pop = 0; both = 0; cyc = 0;
    repeat (3000) begin
      @(negedge Clk);
      cyc++;
      if (dq_push) n_push++;
      if (dq_pop_back) n_pop++;
      if (dq_push && (dq_pop_back || dq_pop_front)) both = 1;
      if (Done || Fail) begin timed_out = 0; break; end
    end
    model(sx, sy, gx, gy, mode);
    $display("search s=(%0d,%0d) g=(%0d,%0d) mode=%0d depth=%0d: done=%0d steps=%0d pops=%0d | model win=%0d steps=%0d pops=%0d",
             sx, sy, gx, gy, mode, dq_depth, Done, step_count, n_pop, m_win, m_steps, m_pops);
    chk("timeout", timed_out, 0);
    chk("done", Done, m_win);
    chk("fail_flag", Fail, (m_win == 0));
    chk("busy_end", busy, 0);
    chk("steps", step_count, m_steps);
    chk("cur_x", cur_x, m_curx);
    chk("cur_y", cur_y, m_cury);
    chk("pushes", n_push, m_steps);
    chk("pops", n_pop, m_pops);
    chk("push_pop_excl", both, 0);
    if (m_win != 0 && Done) replay(gx, gy);
  endtask

  initial begin
    int cyc, seen;
    foreach (wall[i]) wall[i] = 1'b0;
    repeat (2) @(negedge Clk);
    chk("reset_outs", outs, 0);
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("idle_outs", outs, 0);

    // Open maze, straight run right.
    search(0, 0, 3, 0, 1, cyc);
    // Start equals goal: win two cycles after release, nothing pushed.
    search(5, 5, 5, 5, 2, cyc);
    chk("win_latency", cyc, 2);
    // Dead-end pocket forces one backtrack before reaching the goal.
    foreach (wall[i]) wall[i] = 1'b0;
    wall[1*16 + 0] = 1'b1; wall[1*16 + 1] = 1'b1; wall[4*16 + 2] = 1'b1;
    wall[3*16 + 3] = 1'b1; wall[3*16 + 1] = 1'b1; wall[2*16 + 3] = 1'b1;
    search(0, 0, 0, 2, 0, cyc);
    // Walled-in start.
    foreach (wall[i]) wall[i] = 1'b0;
    wall[0*16 + 1] = 1'b1; wall[1*16 + 0] = 1'b1;
    search(0, 0, 9, 9, 0, cyc);
    // Step limit on an open maze.
    foreach (wall[i]) wall[i] = 1'b0;
    search(0, 0, 15, 15, 0, cyc);
    // Deque full on the second move.
    dq_depth = 1;
    search(0, 0, 9, 0, 1, cyc);
    dq_depth = 64;

    // Asynchronous reset while waiting on a slow read, then a clean rerun.
    lat_fixed = 3;
    clear_visited();
    start_x = 0; start_y = 0; goal_x = 9; goal_y = 0; prio_mode = 2'd1;
    Start = 1'b1;
    @(negedge Clk) Start = 1'b0;
    seen = 0;
    repeat (50) begin
      @(negedge Clk);
      if (mem_rd) begin seen = 1; break; end
    end
    chk("rd_seen", seen, 1);
    @(negedge Clk);
    chk("wait_busy", busy, 1);
    #2 Rst_n = 1'b0;
    #1 chk("async_reset_outs", outs, 0);
    @(negedge Clk) Rst_n = 1'b1;
    search(0, 0, 9, 0, 1, cyc);
    lat_fixed = 0;

    for (int t = 0; t < 12; t++) begin
      foreach (wall[i]) wall[i] = ($urandom_range(0, 99) < 25);
      search(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)), cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maze_dfs_ctrl.md
Name: maze_dfs_ctrl

Overview:
- Parametrised depth-first maze-solver controller, the successor to the fixed 16x16 Up/Right/Left/Down solver FSM.
- Owns the current-position registers internally, with per-direction bounds checking and four selectable direction-priority modes.
- Talks to an external maze memory over a variable-latency read handshake, and to an external 2-bit path deque (stack during search, queue during replay).
- Adds visited marking, configurable start/goal, a step-limit timeout, and restart via Start without a global reset.

Parameters:
- CW, 4, coordinate width; maze is 2^CW x 2^CW cells.
- MAX_STEPS, 1024, search fails after this many successful moves.
- SCW, 11, step counter width; must satisfy 2^SCW > MAX_STEPS.

Ports:
- Clk  in  1  clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Start  in  1  level; search begins on its falling edge (press-release).
- Run  in  1  in WIN, starts path replay.
- prio_mode  in  2  direction order, sampled at search start.
- start_x, start_y  in  CW  start cell, sampled at search start.
- goal_x, goal_y  in  CW  goal cell, sampled at search start.
- mem_x, mem_y  out  CW  maze memory address.
- mem_rd  out  1  one-cycle read request.
- mem_valid  in  1  read data valid; arrives 1..N cycles after mem_rd.
- mem_dout  in  1  1 = wall or visited.
- mem_wr  out  1  write 1 (visited) to mem_x/mem_y.
- dq_clr  out  1  clears the deque.
- dq_push  out  1  push dq_din at the back.
- dq_din  out  2  direction pushed.
- dq_pop_back  out  1  pop from the back.
- dq_pop_front  out  1  pop from the front.
- dq_back, dq_front  in  2  back and front entries.
- dq_empty, dq_full  in  1  deque status.
- cur_x, cur_y  out  CW  current position.
- step_count  out  SCW  successful moves this search.
- busy  out  1  high in all states except IDLE, WIN, FAIL, HOLD.
- Done, Fail  out  1  level outputs in WIN / FAIL.
- path_valid  out  1  high on each replay step.
- path_dir  out  2  direction of that replay step.

Behaviour:
- Reset: state IDLE; all outputs 0; cur = 0; step_count = 0; k = 0.
- Direction encoding: 00 up (y+1), 01 right (x+1), 10 left (x-1), 11 down (y-1).
- Priority order by mode: 00 U,R,L,D; 01 R,U,D,L; 10 D,L,R,U; 11 L,D,U,R. k (0..3) indexes the order.
- States and transitions:
  - IDLE: waits for Start = 1, then goes to ARM.
  - ARM: waits for Start = 0, then goes to INIT.
  - INIT (1 cycle): sample prio_mode, start and goal; cur = start; dq_clr = 1; mem_wr visited at start; step_count = 0; k = 0. If start == goal, go to WIN, otherwise TRY.
  - TRY: candidate = cur stepped in order[mode][k]. If the step would wrap (x/y = 2^CW-1 going +, or 0 going -), go to NEXT; otherwise present the candidate on mem_x/mem_y and go to RD.
  - RD: mem_rd = 1 for one cycle, then go to WAIT.
  - WAIT: address held stable until mem_valid. mem_dout = 1 goes to NEXT; mem_dout = 0 goes to MOVE.
  - MOVE (1 cycle): if dq_full, go to FAIL. Otherwise: mem_wr at the candidate; dq_push with dq_din = direction; cur = candidate; step_count + 1; k = 0. Then:
    - cur == goal: go to WIN (goal has priority over timeout on the same cycle).
    - step_count reaches MAX_STEPS: go to FAIL.
    - otherwise: go to TRY.
  - NEXT: if k == 3, go to BACK; otherwise k + 1 and go to TRY.
  - BACK: if dq_empty, go to FAIL; otherwise go to POP.
  - POP (1 cycle): dq_pop_back = 1; cur steps opposite to dq_back; k = 0; go to TRY. Visited marks prevent re-entry.
  - WIN: Done = 1. Run goes to REPLAY_INIT. Start goes to ARM (new search).
  - REPLAY_INIT (1 cycle): cur = sampled start; go to REPLAY.
  - REPLAY: each cycle with !dq_empty: dq_pop_front = 1, path_valid = 1, path_dir = dq_front, cur steps by dq_front. When dq_empty, go to HOLD.
  - HOLD / FAIL: hold state; FAIL drives Fail = 1. Start goes to ARM.
- Output timing: control outputs are Moore-decoded from state; cur and step_count are registered.
- Deque access: push and pop are never asserted in the same cycle.
- Reset mid-operation: immediate return to IDLE. Visited marks in memory are not cleared; clearing them is the memory owner's job.
- Start is ignored while busy.

Decomposition:
- Package maze_pkg:
  - dir_t enum (UP, RIGHT, LEFT, DOWN).
  - state_t enum.
  - function opposite(dir_t).
  - function order(mode, k) returning dir_t.
- Sub-module maze_step_unit (combinational): inputs cur, dir; outputs next_x, next_y, out_of_bounds. Used for TRY, POP (opposite) and REPLAY.

Test Plan:
- Open 16x16 maze, start (0,0), goal (3,0), mode 01 -> 3 moves right, Done = 1, step_count = 3; replay gives path_dir 01,01,01, then HOLD.
- Start = goal = (5,5) -> WIN 2 cycles after Start release; no dq_push.
- Goal (0,2) with walls at (0,1) and (1,1), mode 00, start (0,0) -> dead-end backtrack seen as POP with dq_pop_back, final path reaches (0,2), Done = 1.
- Fully walled start (0,0), walls at (1,0) and (0,1) -> BACK with dq_empty, Fail = 1, step_count = 0.
- MAX_STEPS = 4, goal unreachable at distance 10 -> Fail exactly on the 4th MOVE; dq_full forced high at the 2nd push -> Fail without push.
- mem_valid latency 3 cycles, Rst_n low during WAIT -> all outputs 0 asynchronously, state IDLE; a new Start/release then reruns the search correctly.
